// File: rtl/stream_mux_nx1.sv
// Purpose: N-to-1 valid/ready stream mux; source picked by static select or by arbitration.
// Latency: one cycle. An input handshake at edge k is visible on out_* after edge k.
// Backpressure: out_valid=1 with out_ready=0 holds the output register and drops every in_ready.
// Build option STREAM_MUX_RR_EN: round-robin arbitration (undefined: fixed priority, lowest index wins).
module stream_mux_nx1 #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)  // derived from N; leave at its default
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           sel_mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_sel
);

  logic          load_en;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  gnt_dat;
  logic [N-1:0]  gnt;

`ifdef STREAM_MUX_RR_EN
  logic [SW-1:0] ptr;
  int            best;
  int            dist;
`endif

  // The output register can take a new word when empty or being drained this cycle.
  // rst_n is folded in so no source sees ready (and believes it handed off) during reset.
  assign load_en = rst_n & (~out_valid | out_ready);

  // Pick at most one granted channel and its data.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_dat = '0;
`ifdef STREAM_MUX_RR_EN
    best    = N;
    dist    = 0;
`endif
    if (sel_mode) begin
      // Static select: an out-of-range sel matches no channel, so nothing is granted.
      for (int i = 0; i < N; i++) begin
        if ((SW'(i) == sel) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'(i);
          gnt_dat = in_data[i*W +: W];
        end
      end
    end else begin
`ifdef STREAM_MUX_RR_EN
      // Round robin: the valid channel closest to ptr, counting upward with wrap, wins.
      for (int i = 0; i < N; i++) begin
        if (in_valid[i]) begin
          dist = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N - int'(ptr));
          if (dist < best) begin
            best    = dist;
            gnt_vld = 1'b1;
            gnt_idx = SW'(i);
            gnt_dat = in_data[i*W +: W];
          end
        end
      end
`else
      // Fixed priority: lowest valid index wins.
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && !gnt_vld) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'(i);
          gnt_dat = in_data[i*W +: W];
        end
      end
`endif
    end
  end

  // Expand the winning index into a one-hot grant vector.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = gnt_vld && (gnt_idx == SW'(i));
    end
  end

  assign in_ready = gnt & {N{load_en}};

  // Output register: load the granted word, or go empty when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load_en) begin
      if (gnt_vld) begin
        out_valid <= 1'b1;
        out_data  <= gnt_dat;
        out_sel   <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef STREAM_MUX_RR_EN
  // Arbitration pointer moves just past the channel that won an arbitrated transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load_en && gnt_vld && !sel_mode) begin
      ptr <= (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux_nx1.sv
module tb_stream_mux_nx1;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           sel_mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_sel;

  int tests = 0;
  int fails = 0;

  // Reference state: contents of the output stage and the arbitration start point.
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;

  always #5 clk = ~clk;

  stream_mux_nx1 #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel_mode  (sel_mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  // Which channel should win right now, or -1 for none.
  function automatic int ref_pick();
    if (sel_mode)
      return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 0; k < N; k++) begin
      int c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  // One clock cycle: check ready with settled inputs, clock, check the output stage.
  task automatic step(input string tag);
    int           g;
    bit           ld;
    logic [N-1:0] er;
    #2;
    ld = rst_n && (!m_valid || out_ready);
    g  = ref_pick();
    er = '0;
    if (ld && g >= 0) er[g] = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(er));
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_sel   = g;
`ifdef STREAM_MUX_RR_EN
        if (!sel_mode) m_ptr = (g + 1) % N;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".out_data"},  32'(out_data),  32'(m_data));
    check({tag, ".out_sel"},   32'(out_sel),   32'(m_sel));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '1;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    sel_mode  = 1'b0;
    sel       = '0;
    out_ready = 1'b1;
    model_reset();

    // Reset held with every source valid: nothing ready, output empty.
    #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_sel",   32'(out_sel),   32'd0);
    check("rst.out_data",  32'(out_data),  32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd0);
    step("rst_hold0");
    step("rst_hold1");

    // First arbitrated transfer after release.
    rst_n = 1'b1;
    step("first");

    // All sources valid, consumer always ready.
    for (int i = 0; i < 8; i++) step("all_valid");

    // Sparse valid patterns.
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) step("v1010");
    in_valid = 4'b1000;
    for (int i = 0; i < 2; i++) step("v1000");

    // Static select of channel 2, then channel 2 goes idle.
    sel_mode = 1'b1;
    sel      = 2'd2;
    in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) step("static2");
    in_valid = 4'b1011;
    step("static2_idle");

    // Output backpressure then release with back-to-back load.
    sel_mode = 1'b0;
    in_valid = 4'b1111;
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    step("bp_load");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("bp_hold");
    out_ready = 1'b1;
    in_data   = {8'h23, 8'h22, 8'h21, 8'h20};
    step("bp_release");
    step("bp_next");

    // Move the pointer to 3, then channels 3 and 0 compete.
    in_valid = 4'b0100;
    step("wrap_setup");
    in_valid = 4'b1001;
    step("wrap_a");
    step("wrap_b");

    // Reset pulse while the output stage is full and stalled.
    in_valid  = 4'b1111;
    step("mid_fill");
    out_ready = 1'b0;
    step("mid_stall");
    rst_n = 1'b0;
    #1;
    check("mid_rst.out_valid", 32'(out_valid), 32'd0);
    check("mid_rst.in_ready",  32'(in_ready),  32'd0);
    model_reset();
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step("after_rst");

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      sel_mode  = ($urandom_range(0, 4) == 0);
      sel       = 2'($urandom_range(0, 3));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
